multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have these ports, one clock domain, each listed as name, direction, width and meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- instr  in  32  instruction-memory read data; opcode = instr[31:26]
- imem_ready  in  1  fetch data valid
- dmem_ready  in  1  data-memory access complete
- imem_req  out  1  fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- branch  out  1  conditional PC update; datapath gates it with ALU zero
- alu_src  out  1  1 = immediate operand
- alu_op  out  3  ALU operation
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = writeback from memory
- reg_write  out  1  register-file write enable
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (valid with dmem_req)
- state  out  3  current state encoding
- illegal  out  1  sticky illegal-opcode flag
- retired  out  16  retired-instruction count

Function
REQ-002 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-003 All outputs SHALL be Moore outputs, decoded only from state and the latched opcode.
REQ-004 FETCH SHALL behave as follows:
- imem_req=1 in every FETCH cycle.
- On a cycle with imem_ready=1: ir_write=1, pc_write=1, pc_src=0, opcode latched from instr[31:26], next state DECODE.
- On a cycle with imem_ready=0: stay in FETCH with no strobes.
REQ-005 DECODE SHALL take one cycle and act on the latched opcode:
- Jump 110000: pc_write=1, pc_src=2, retire, next state FETCH.
- Undefined opcode: next state TRAP.
- Any other defined opcode: next state EXEC.
REQ-006 Defined opcodes and their alu_op values SHALL be:
- R-type 000000: 010
- addi 010000: 011
- andi 010001: 100
- xori 010010: 101
- beq 010011: 001
- lw 010101: 000
- sw 010110: 000
- slt 010111: 010
- slti 011000: 110
- jump 110000: 111
REQ-007 alu_op SHALL hold the latched opcode's value in DECODE through WB; alu_src=1 for addi, andi, xori, slti, lw and sw.
REQ-008 EXEC SHALL take one cycle and branch by opcode:
- beq: branch=1, pc_src=1, retire, next state FETCH.
- lw or sw: next state MEM.
- All others: next state WB.
REQ-009 MEM SHALL hold dmem_req=1 every cycle until dmem_ready=1, with dmem_we=1 only for sw; on dmem_ready, lw SHALL go to WB and sw SHALL retire and go to FETCH.
REQ-010 WB SHALL take one cycle with these outputs, then retire and go to FETCH:
- reg_write=1
- reg_dst=1 for R-type and slt, else 0
- mem_to_reg=1 only for lw
REQ-011 In TRAP, illegal SHALL be 1, all strobes SHALL be 0, and the block SHALL stay in TRAP until reset.
REQ-012 Strobes not named for a state SHALL be 0 in that state.
REQ-013 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-014 retired SHALL increment by 1 on each retiring transition and wrap from 0xFFFF to 0x0000.
REQ-015 Cycle counts SHALL be:
- jump: 2 + fetch wait
- beq: 3 + fetch wait
- R-type and I-type ALU: 4 + fetch wait
- sw: 4 + fetch wait + mem wait
- lw: 5 + fetch wait + mem wait

Reset
REQ-016 Asserting reset SHALL immediately, without waiting for a clock edge, set:
- state=FETCH
- latched opcode=000000
- illegal=0
- retired=0
REQ-017 While reset is high, imem_req SHALL be 1 and every other output SHALL be 0.
REQ-018 Reset asserted mid-MEM SHALL drop dmem_req and dmem_we immediately, with no retire.
REQ-019 After reset deasserts, the first fetch SHALL be accepted on the first rising edge with imem_ready=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, imem_ready=1, instr=addi: states 0,1,2,4,0; reg_write=1 only in WB; alu_op=011; alu_src=1; retired=1.
- lw with dmem_ready delayed 3 cycles: dmem_req=1 for 4 cycles, dmem_we=0; WB has mem_to_reg=1, reg_dst=0; total 8 cycles.
- sw then beq: sw has dmem_we=1 and no WB; beq EXEC has branch=1, pc_src=1; retired=2.
- Jump 110000: DECODE has pc_write=1, pc_src=2; returns to FETCH after 2 cycles; alu_op=111.
- Opcode 111111: TRAP; illegal=1 held 20 cycles with strobes 0; reset clears it.
- Preload retired=0xFFFF via 65535 retires, then one more retire: retired=0x0000; a mid-MEM reset gives dmem_req=0 before the next edge.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP FSM driving a
// single-bus datapath from a latched opcode, with a retired-instruction counter.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        branch,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;
  localparam logic [5:0] OP_SLT   = 6'b010111;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_JUMP  = 6'b110000;

  logic [2:0]  r_state;
  logic [5:0]  r_opcode;
  logic        r_illegal;
  logic [15:0] r_retired;

  logic [2:0]  w_next_state;
  logic        w_retire;
  logic        w_defined;
  logic [2:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_is_jump;
  logic        w_is_beq;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_rd;
  logic        w_fetch_accept;
  logic        w_alu_phase;
  logic        w_unused_instr;

  // Only the opcode field steers control; operand fields belong to the datapath.
  assign w_unused_instr = ^instr[25:0];

  // Opcode classification, all from the latched opcode.
  always_comb begin
    w_defined = 1'b1;
    w_alu_op  = 3'b000;
    w_alu_src = 1'b0;
    case (r_opcode)
      OP_RTYPE: w_alu_op = 3'b010;
      OP_ADDI:  begin w_alu_op = 3'b011; w_alu_src = 1'b1; end
      OP_ANDI:  begin w_alu_op = 3'b100; w_alu_src = 1'b1; end
      OP_XORI:  begin w_alu_op = 3'b101; w_alu_src = 1'b1; end
      OP_BEQ:   w_alu_op = 3'b001;
      OP_LW:    begin w_alu_op = 3'b000; w_alu_src = 1'b1; end
      OP_SW:    begin w_alu_op = 3'b000; w_alu_src = 1'b1; end
      OP_SLT:   w_alu_op = 3'b010;
      OP_SLTI:  begin w_alu_op = 3'b110; w_alu_src = 1'b1; end
      OP_JUMP:  w_alu_op = 3'b111;
      default:  w_defined = 1'b0;
    endcase
  end

  assign w_is_jump = (r_opcode == OP_JUMP);
  assign w_is_beq  = (r_opcode == OP_BEQ);
  assign w_is_lw   = (r_opcode == OP_LW);
  assign w_is_sw   = (r_opcode == OP_SW);
  assign w_is_rd   = (r_opcode == OP_RTYPE) || (r_opcode == OP_SLT);

  // Fetch strobes qualify on imem_ready so a stalled fetch never advances the PC.
  assign w_fetch_accept = (r_state == S_FETCH) && imem_ready && !reset;
  assign w_alu_phase    = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                          (r_state == S_MEM)    || (r_state == S_WB);

  always_comb begin
    w_next_state = S_FETCH;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH:  w_next_state = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_jump) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else if (!w_defined) begin
          w_next_state = S_TRAP;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_beq) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else if (w_is_lw || w_is_sw) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (!dmem_ready) begin
          w_next_state = S_MEM;
        end else if (w_is_sw) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    if (w_alu_phase) begin
      alu_op  = w_alu_op;
      alu_src = w_alu_src;
    end
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = w_fetch_accept;
        pc_write = w_fetch_accept;
      end
      S_DECODE: begin
        if (w_is_jump) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
      end
      S_EXEC: begin
        if (w_is_beq) begin
          branch = 1'b1;
          pc_src = 2'd1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = w_is_rd;
        mem_to_reg = w_is_lw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opcode <= 6'b000000;
    end else if ((r_state == S_FETCH) && imem_ready) begin
      r_opcode <= instr[31:26];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_DECODE) && !w_defined) begin
      r_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= 16'h0000;
    end else if (w_retire) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed scoreboard bench for multicycle_sequencer: per-cycle expected outputs
// are queued from an instruction-level model and compared as the DUT steps.
module tb_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        branch;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] retired;

  multicycle_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .branch     (branch),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .state      (state),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;
  localparam logic [5:0] OP_SLT   = 6'b010111;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_JUMP  = 6'b110000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  typedef struct packed {
    logic [2:0]  state;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic        illegal;
    logic [15:0] retired;
  } out_t;

  typedef struct {
    string       tag;
    logic        ir;
    logic        dr;
    logic [31:0] ins;
    out_t        exp;
  } entry_t;

  out_t        obs;
  entry_t      sb[$];
  int          n_pass;
  int          n_total;
  logic [15:0] m_ret;

  assign obs = {state, imem_req, ir_write, pc_write, pc_src, branch, alu_src, alu_op,
                reg_dst, mem_to_reg, reg_write, dmem_req, dmem_we, illegal, retired};

  function automatic logic [2:0] m_aluop(input logic [5:0] op);
    case (op)
      OP_RTYPE: return 3'b010;
      OP_ADDI:  return 3'b011;
      OP_ANDI:  return 3'b100;
      OP_XORI:  return 3'b101;
      OP_BEQ:   return 3'b001;
      OP_SLT:   return 3'b010;
      OP_SLTI:  return 3'b110;
      OP_JUMP:  return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic m_defined(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_XORI) ||
           (op == OP_BEQ) || (op == OP_LW) || (op == OP_SW) || (op == OP_SLT) ||
           (op == OP_SLTI) || (op == OP_JUMP);
  endfunction

  function automatic logic m_alusrc(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_XORI) ||
           (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic out_t reset_vec();
    out_t r;
    r = '0;
    r.imem_req = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input out_t o, input out_t e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic add(input string tag, input logic ir, input logic dr,
                     input logic [31:0] ins, input out_t e);
    entry_t en;
    en.tag = tag;
    en.ir  = ir;
    en.dr  = dr;
    en.ins = ins;
    en.exp = e;
    sb.push_back(en);
  endtask

  task automatic push_idle(input string name);
    out_t o;
    o = '0;
    o.imem_req = 1'b1;
    o.retired  = m_ret;
    add({name, "_idle"}, 1'b0, 1'b0, 32'h0, o);
  endtask

  // Builds the full expected cycle sequence of one instruction.
  task automatic push_instr(input string name, input logic [5:0] op, input int fwait,
                            input int mwait, input logic noise);
    out_t        o;
    logic [31:0] ins;
    logic [25:0] low;
    low = 26'($urandom);
    ins = {op, low};
    $display("txn %s op=%b fetch_wait=%0d mem_wait=%0d retired_before=%0d",
             name, op, fwait, mwait, m_ret);
    o = '0;
    o.imem_req = 1'b1;
    o.retired  = m_ret;
    for (int k = 0; k < fwait; k++) add({name, "_fwait"}, 1'b0, noise, ins, o);
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    add({name, "_fetch"}, 1'b1, noise, ins, o);
    o = '0;
    o.retired = m_ret;
    o.state   = 3'd1;
    if (!m_defined(op)) begin
      add({name, "_dec"}, noise, noise, ins, o);
      o.state   = 3'd5;
      o.illegal = 1'b1;
      for (int k = 0; k < 20; k++) add({name, "_trap"}, (k % 2 == 1), (k % 2 == 0), ins, o);
      return;
    end
    o.alu_op  = m_aluop(op);
    o.alu_src = m_alusrc(op);
    if (op == OP_JUMP) begin
      o.pc_write = 1'b1;
      o.pc_src   = 2'd2;
      add({name, "_dec"}, noise, noise, ins, o);
      m_ret++;
      return;
    end
    add({name, "_dec"}, noise, noise, ins, o);
    o.state = 3'd2;
    if (op == OP_BEQ) begin
      o.branch = 1'b1;
      o.pc_src = 2'd1;
      add({name, "_exec"}, noise, noise, ins, o);
      m_ret++;
      return;
    end
    add({name, "_exec"}, noise, noise, ins, o);
    if (op == OP_LW || op == OP_SW) begin
      o.state    = 3'd3;
      o.dmem_req = 1'b1;
      o.dmem_we  = (op == OP_SW);
      for (int k = 0; k <= mwait; k++) add({name, "_mem"}, noise, (k == mwait), ins, o);
      if (op == OP_SW) begin
        m_ret++;
        return;
      end
      o.dmem_req = 1'b0;
      o.dmem_we  = 1'b0;
    end
    o.state      = 3'd4;
    o.reg_write  = 1'b1;
    o.reg_dst    = (op == OP_RTYPE) || (op == OP_SLT);
    o.mem_to_reg = (op == OP_LW);
    add({name, "_wb"}, noise, noise, ins, o);
    m_ret++;
  endtask

  task automatic step_one();
    entry_t en;
    en = sb.pop_front();
    imem_ready = en.ir;
    dmem_ready = en.dr;
    instr      = en.ins;
    #1;
    check(en.tag, obs, en.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_sb();
    while (sb.size() > 0) step_one();
  endtask

  task automatic apply_reset(input string tag);
    reset      = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check({tag, "_async"}, obs, reset_vec());
    @(posedge clk);
    #1;
    check({tag, "_hold"}, obs, reset_vec());
    #2;
    reset = 1'b0;
    m_ret = 16'h0000;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    m_ret      = 16'h0000;
    reset      = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    instr      = {OP_ADDI, 26'h0};
    apply_reset("por");

    push_instr("addi", OP_ADDI, 0, 0, 1'b0);
    push_instr("lw", OP_LW, 0, 3, 1'b1);
    push_instr("sw", OP_SW, 0, 1, 1'b0);
    push_instr("beq", OP_BEQ, 1, 0, 1'b1);
    push_instr("jump", OP_JUMP, 2, 0, 1'b1);
    push_instr("rtype", OP_RTYPE, 0, 0, 1'b0);
    push_instr("andi", OP_ANDI, 1, 0, 1'b1);
    push_instr("xori", OP_XORI, 0, 0, 1'b0);
    push_instr("slt", OP_SLT, 0, 0, 1'b1);
    push_instr("slti", OP_SLTI, 3, 0, 1'b0);
    push_idle("after_alu");
    push_instr("bad", OP_BAD, 0, 0, 1'b1);
    run_sb();

    apply_reset("trap_clear");
    push_idle("post_trap");
    run_sb();

    // Walk the counter to 0xFFFF with back-to-back two-cycle jumps.
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    instr      = {OP_JUMP, 26'h0};
    repeat (131070) @(posedge clk);
    #1;
    m_ret = 16'hFFFF;
    push_instr("jump_wrap", OP_JUMP, 0, 0, 1'b0);
    push_instr("addi_wrap", OP_ADDI, 0, 0, 1'b0);
    push_instr("lw_cut", OP_LW, 0, 5, 1'b0);
    for (int k = 0; k < 4; k++) step_one();
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_mem", obs, reset_vec());
    sb.delete();
    m_ret = 16'h0000;
    @(posedge clk);
    #1;
    check("reset_mid_mem_hold", obs, reset_vec());
    #2;
    reset = 1'b0;
    push_instr("addi_post", OP_ADDI, 1, 0, 1'b1);
    push_idle("final");
    run_sb();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
